// File: rtl/bcd_result_recomp_if.sv
// Handshake bundle between the BCD adder array, the result re-complementer and the output register.
interface bcd_result_recomp_if #(
  parameter int unsigned NDIG = 3
) ();
  localparam int unsigned W = 4 * NDIG;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] raw;
  logic         cout;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic         sign;
  logic [W-1:0] mag;
  logic         err;

  modport slave (
    input  in_valid, raw, cout, sub, out_ready,
    output in_ready, out_valid, sign, mag, err
  );

  modport master (
    output in_valid, raw, cout, sub, out_ready,
    input  in_ready, out_valid, sign, mag, err
  );
endinterface

// File: rtl/bcd_result_recomp.sv
// Converts a raw 10's-complement BCD adder result into sign-magnitude BCD,
// re-complementing negative results serially one digit per clock, LSD first.
module bcd_result_recomp #(
  parameter int unsigned NDIG = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_result_recomp_if.slave  bus
);
  localparam int unsigned W     = 4 * NDIG;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, PASS, CONV, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     raw_q, raw_d;
  logic             cout_q, cout_d;
  logic             sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     mag_q, mag_d;
  logic             err_q, err_d;

  logic [3:0]       dig;
  logic [4:0]       t;
  logic [3:0]       new_dig;
  logic             c_nxt;
  logic [W-1:0]     acc_nxt;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One digit of the 9's complement plus incoming carry; 9-d wraps for illegal digits.
  always_comb begin
    dig = 4'd0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx_q == IDX_W'(i)) dig = raw_q[i*4 +: 4];
    end
    t       = {1'b0, 4'(4'd9 - dig)} + {4'd0, c_q};
    c_nxt   = (t == 5'd10);
    new_dig = c_nxt ? 4'd0 : t[3:0];
    acc_nxt = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx_q == IDX_W'(i)) acc_nxt[i*4 +: 4] = new_dig;
    end
  end

  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    cout_d  = cout_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          raw_d   = bus.raw;
          cout_d  = bus.cout;
          sub_d   = bus.sub;
          idx_d   = '0;
          c_d     = 1'b1;
          acc_d   = '0;
          state_d = (!bus.sub || bus.cout) ? PASS : CONV;
        end
      end
      PASS: begin
        mag_d   = raw_q;
        sign_d  = 1'b0;
        err_d   = has_bad_digit(raw_q) | (!sub_q & cout_q);
        state_d = DONE;
      end
      CONV: begin
        acc_d = acc_nxt;
        c_d   = c_nxt;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NDIG - 1)) begin
          // raw == 0 here means the true result is -10^NDIG, which has no representation.
          mag_d   = acc_nxt;
          sign_d  = (acc_nxt != '0);
          err_d   = has_bad_digit(raw_q) | (raw_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      raw_q       <= '0;
      cout_q      <= 1'b0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      raw_q       <= raw_d;
      cout_q      <= cout_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sign      = sign_q;
  assign bus.mag       = mag_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_result_recomp.sv
// Randomized bench for bcd_result_recomp against a decimal-arithmetic reference model.
module tb_bcd_result_recomp;
  localparam int unsigned NDIG = 3;
  localparam int unsigned W    = 4 * NDIG;

  logic clk;
  logic rst_n;

  bcd_result_recomp_if #(.NDIG(NDIG)) bus ();

  bcd_result_recomp #(.NDIG(NDIG)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Job tracking filled in at the accept edge
  logic         job_active = 1'b0;
  int           edges      = 0;
  int           since_rst  = 0;
  int           acc_count  = 0;
  int           exp_lat    = 0;
  logic         exp_sign   = 1'b0;
  logic [W-1:0] exp_mag    = '0;
  logic         exp_err    = 1'b0;
  logic         ms;
  logic [W-1:0] mm;
  logic         me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = x;
    for (int i = 0; i < int'(NDIG); i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal reference: positive results pass through, negative ones are 10^NDIG - value.
  function automatic void model(input logic [W-1:0] r, input logic co, input logic sb,
                                output logic s, output logic [W-1:0] m, output logic e);
    logic       bad;
    int         v;
    int         p;
    int         d;
    int         c;
    int         tt;
    bad = 1'b0;
    v = 0;
    p = 1;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = int'(r[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      v = v + d * p;
      p = p * 10;
    end
    if (!sb || co) begin
      m = r;
      s = 1'b0;
      e = bad || (!sb && co);
    end else if (!bad) begin
      if (v == 0) begin
        m = '0;
        s = 1'b0;
        e = 1'b1;
      end else begin
        m = to_bcd(p - v);
        s = 1'b1;
        e = 1'b0;
      end
    end else begin
      c = 1;
      m = '0;
      for (int i = 0; i < int'(NDIG); i++) begin
        d  = int'(r[i*4 +: 4]);
        tt = ((9 - d) & 15) + c;
        if (tt == 10) begin
          m[i*4 +: 4] = 4'd0;
          c = 1;
        end else begin
          m[i*4 +: 4] = 4'(tt % 16);
          c = 0;
        end
      end
      s = (m != '0);
      e = 1'b1;
    end
  endfunction

  // Accept/handshake monitor: records the expected result and latency for each job.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_active <= 1'b0;
      since_rst  <= 0;
      edges      <= 0;
    end else begin
      if (since_rst < 2) since_rst <= since_rst + 1;
      if (job_active) begin
        edges <= edges + 1;
        if (bus.out_valid && bus.out_ready) job_active <= 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.raw, bus.cout, bus.sub, ms, mm, me);
        exp_sign   <= ms;
        exp_mag    <= mm;
        exp_err    <= me;
        exp_lat    <= (!bus.sub || bus.cout) ? 2 : int'(NDIG) + 1;
        job_active <= 1'b1;
        edges      <= 1;
        acc_count  <= acc_count + 1;
      end
    end
  end

  // Per-cycle output compare, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'({bus.in_ready, bus.out_valid, bus.sign, bus.mag, bus.err}), 32'd0);
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(since_rst >= 1 && !job_active));
      check("out_valid", 32'(bus.out_valid), 32'(job_active && edges >= exp_lat));
      if (job_active && edges >= exp_lat && bus.out_valid) begin
        check("sign", 32'(bus.sign), 32'(exp_sign));
        check("mag", 32'(bus.mag), 32'(exp_mag));
        check("err", 32'(bus.err), 32'(exp_err));
      end
    end
  end

  task automatic send(input logic [W-1:0] r, input logic co, input logic sb);
    int base;
    int n;
    base = acc_count;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.raw      = r;
    bus.cout     = co;
    bus.sub      = sb;
    do begin
      @(negedge clk);
      n++;
    end while (acc_count == base && n < 50);
    bus.in_valid = 1'b0;
    check("accept", 32'(acc_count), 32'(base + 1));
  endtask

  // Runs the job to its output handshake while throwing ignored traffic at the input.
  task automatic drain(input int hold, input bit rnd);
    int n;
    int h;
    n = 0;
    h = hold;
    while (job_active && n < 200) begin
      bus.in_valid = 1'($urandom % 2);
      bus.raw      = W'($urandom);
      bus.cout     = 1'($urandom % 2);
      bus.sub      = 1'($urandom % 2);
      if (bus.out_valid && h > 0) begin
        bus.out_ready = 1'b0;
        h--;
      end else begin
        bus.out_ready = rnd ? 1'(($urandom % 3) != 0) : 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("job_done", 32'(job_active), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_raw();
    logic [W-1:0] r;
    int mode;
    mode = int'($urandom % 10);
    r = '0;
    if (mode == 1) begin
      r = W'($urandom);
    end else if (mode != 0) begin
      for (int i = 0; i < int'(NDIG); i++) r[i*4 +: 4] = 4'($urandom % 10);
    end
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         s;
    logic [W-1:0] m;
    logic         e;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.raw       = '0;
    bus.cout      = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed anchors for the reference model
    model(12'h753, 1'b1, 1'b1, s, m, e); check("model_pos", 32'({s, m, e}), 32'({1'b0, 12'h753, 1'b0}));
    model(12'h753, 1'b0, 1'b1, s, m, e); check("model_neg", 32'({s, m, e}), 32'({1'b1, 12'h247, 1'b0}));
    model(12'h001, 1'b0, 1'b1, s, m, e); check("model_001", 32'({s, m, e}), 32'({1'b1, 12'h999, 1'b0}));
    model(12'h990, 1'b0, 1'b1, s, m, e); check("model_990", 32'({s, m, e}), 32'({1'b1, 12'h010, 1'b0}));
    model(12'h000, 1'b0, 1'b1, s, m, e); check("model_m1000", 32'({s, m, e}), 32'({1'b0, 12'h000, 1'b1}));
    model(12'h7A3, 1'b1, 1'b1, s, m, e); check("model_illegal", 32'(e), 32'd1);
    model(12'h123, 1'b1, 1'b0, s, m, e); check("model_ovf", 32'(e), 32'd1);

    // Directed cases
    send(12'h753, 1'b1, 1'b1); drain(0, 1'b0);
    send(12'h753, 1'b0, 1'b1); drain(0, 1'b0);
    send(12'h001, 1'b0, 1'b1); drain(0, 1'b0);
    send(12'h990, 1'b0, 1'b1); drain(0, 1'b0);
    send(12'h000, 1'b0, 1'b1); drain(0, 1'b0);
    send(12'h7A3, 1'b1, 1'b1); drain(0, 1'b0);
    send(12'h123, 1'b1, 1'b0); drain(0, 1'b0);
    send(12'hA5F, 1'b0, 1'b1); drain(0, 1'b0);
    send(12'h753, 1'b0, 1'b1); drain(6, 1'b0);

    // Reset during the second complement cycle abandons the job
    send(12'h753, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_job", 32'({bus.in_ready, bus.out_valid, bus.sign, bus.mag, bus.err}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(12'h753, 1'b1, 1'b1); drain(0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      send(rand_raw(), 1'($urandom % 2), 1'(($urandom % 4) != 0));
      drain(int'($urandom % 4) == 0 ? int'($urandom % 6) : 0, 1'($urandom % 2));
      repeat (int'($urandom % 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
